// File: rtl/mem_wb_stage.sv
// Memory stage plus MEM/WB pipeline register with a req/ack data-memory handshake.
// Optional trace capture of PC/instruction-valid is enabled by MEM_WB_DEBUG_TRACE_EN.
module mem_wb_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wd_sel_i,
    input  logic              rf_we_i,
    input  logic              dram_we_i,
    input  logic [4:0]        wR_i,
    input  logic [DATA_W-1:0] wD_i,
    input  logic [DATA_W-1:0] aluc_i,
    input  logic [DATA_W-1:0] rd2_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
`ifdef MEM_WB_DEBUG_TRACE_EN
    input  logic [31:0]       debug_pc_i,
    input  logic              debug_have_inst_i,
    output logic [31:0]       debug_pc_o,
    output logic              debug_have_inst_o,
`endif
    output logic              stall_o,
    output logic              rf_we_o,
    output logic [4:0]        wR_o,
    output logic [DATA_W-1:0] wD_o
);

    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;

    logic              mem_op;
    logic [DATA_W-1:0] nonmem_wd;
    logic              lat_rf_we;
    logic              lat_load;
    logic [4:0]        lat_wr;
    logic [DATA_W-1:0] lat_wd;
`ifdef MEM_WB_DEBUG_TRACE_EN
    logic [31:0]       lat_pc;
    logic              lat_have;
`endif

    assign mem_op    = dram_we_i | (rf_we_i & (wd_sel_i == 2'b01));
    assign nonmem_wd = (wd_sel_i == 2'b00) ? aluc_i : wD_i;
    // The ack cycle releases the stall so upstream advances on the completing edge.
    assign stall_o   = (state == WAIT) ? ~mem_ack_i : mem_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rf_we_o     <= 1'b0;
            wR_o        <= '0;
            wD_o        <= '0;
            lat_rf_we   <= 1'b0;
            lat_load    <= 1'b0;
            lat_wr      <= '0;
            lat_wd      <= '0;
`ifdef MEM_WB_DEBUG_TRACE_EN
            debug_pc_o        <= '0;
            debug_have_inst_o <= 1'b0;
            lat_pc            <= '0;
            lat_have          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        state       <= WAIT;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= dram_we_i;
                        mem_addr_o  <= aluc_i[ADDR_W-1:0];
                        mem_wdata_o <= rd2_i;
                        lat_rf_we   <= rf_we_i;
                        lat_load    <= (wd_sel_i == 2'b01);
                        lat_wr      <= wR_i;
                        lat_wd      <= nonmem_wd;
                        rf_we_o     <= 1'b0;
`ifdef MEM_WB_DEBUG_TRACE_EN
                        lat_pc            <= debug_pc_i;
                        lat_have          <= debug_have_inst_i;
                        debug_have_inst_o <= 1'b0;
`endif
                    end else begin
                        rf_we_o <= rf_we_i;
                        wR_o    <= wR_i;
                        wD_o    <= nonmem_wd;
`ifdef MEM_WB_DEBUG_TRACE_EN
                        debug_pc_o        <= debug_pc_i;
                        debug_have_inst_o <= debug_have_inst_i;
`endif
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        state     <= IDLE;
                        mem_req_o <= 1'b0;
                        rf_we_o   <= lat_rf_we;
                        wR_o      <= lat_wr;
                        wD_o      <= lat_load ? mem_rdata_i : lat_wd;
`ifdef MEM_WB_DEBUG_TRACE_EN
                        debug_pc_o        <= lat_pc;
                        debug_have_inst_o <= lat_have;
`endif
                    end else begin
                        rf_we_o <= 1'b0;
`ifdef MEM_WB_DEBUG_TRACE_EN
                        debug_have_inst_o <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
